// File: rtl/fp16_add_sched_if.sv
// Bundle of request, shared-adder and response signals for fp16_add_sched.
// slave is the scheduler's view; master is the view of whatever drives it.
interface fp16_add_sched_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [16*N_REQ-1:0] req_a;
  logic [16*N_REQ-1:0] req_b;
  logic [15:0]         add_a;
  logic [15:0]         add_b;
  logic [15:0]         add_ans;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [2:0]          rsp_id;
  logic [15:0]         rsp_data;
  logic                busy;
  logic [15:0]         ops_done;

  modport master (
    output req_valid, req_a, req_b, add_ans, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data, busy, ops_done
  );

  modport slave (
    input  req_valid, req_a, req_b, add_ans, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data, busy, ops_done
  );
endinterface

// File: rtl/fp16_add_sched.sv
// Round-robin scheduler that shares one external fp16 adder among N_REQ
// requesters. One transaction is in flight at a time: grant in IDLE, wait
// ADD_LAT+1 cycles for the adder, then hold the response until accepted.
module fp16_add_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADD_LAT = 1
) (
  input logic              clk,
  input logic              rst_n,
  fp16_add_sched_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e           state_q;
  logic [2:0]       last_grant_q;
  logic [2:0]       rsp_id_q;
  logic [2:0]       wait_cnt_q;
  logic [15:0]      add_a_q;
  logic [15:0]      add_b_q;
  logic [15:0]      rsp_data_q;
  logic [15:0]      ops_done_q;
  logic [15:0]      ops_done_d;
  logic             rsp_valid_q;
  logic             busy_q;

  logic [N_REQ-1:0] grant;
  logic             grant_any;
  logic [2:0]       grant_idx;
  logic [15:0]      sel_a;
  logic [15:0]      sel_b;

  // Round-robin pick starting after last_grant; only offered in IDLE and out of reset.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    sel_a     = '0;
    sel_b     = '0;
    if (rst_n && (state_q == StIdle)) begin
      for (int unsigned off = 1; off <= N_REQ; off++) begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
          if (!grant_any && bus.req_valid[i] &&
              (i == ((32'(last_grant_q) + off) % N_REQ))) begin
            grant_any = 1'b1;
            grant[i]  = 1'b1;
            grant_idx = 3'(i);
            sel_a     = bus.req_a[16*i +: 16];
            sel_b     = bus.req_b[16*i +: 16];
          end
        end
      end
    end
  end

  // Completed-response counter, sticks at all-ones.
  always_comb begin
    ops_done_d = ops_done_q;
    if ((state_q == StResp) && bus.rsp_ready && (ops_done_q != 16'hFFFF)) begin
      ops_done_d = ops_done_q + 16'd1;
    end
  end

  // Main FSM with registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 3'(N_REQ - 1);
      rsp_id_q     <= '0;
      wait_cnt_q   <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      rsp_data_q   <= '0;
      ops_done_q   <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ops_done_q <= ops_done_d;
      case (state_q)
        StIdle: begin
          if (grant_any) begin
            add_a_q      <= sel_a;
            add_b_q      <= sel_b;
            rsp_id_q     <= grant_idx;
            last_grant_q <= grant_idx;
            wait_cnt_q   <= '0;
            busy_q       <= 1'b1;
            state_q      <= StWait;
          end
        end
        StWait: begin
          // ADD_LAT+1 cycles here: the adder needs ADD_LAT after its inputs settle.
          if (wait_cnt_q == 3'(ADD_LAT)) begin
            rsp_data_q  <= bus.add_ans;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + 3'd1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;
  assign bus.ops_done  = ops_done_q;

endmodule

// File: tb/tb_fp16_add_sched.sv
// Scoreboard bench for fp16_add_sched: one instance with ADD_LAT=1 and one
// with ADD_LAT=3, each fed by a table-driven stand-in for the fp16 adder.
module tb_fp16_add_sched;
  localparam int unsigned NR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp16_add_sched_if #(.N_REQ(NR)) bus1 ();
  fp16_add_sched_if #(.N_REQ(NR)) bus3 ();

  fp16_add_sched #(.N_REQ(NR), .ADD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  fp16_add_sched #(.N_REQ(NR), .ADD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  // Hand-computed fp16 sums for the operand pairs used below.
  function automatic logic [15:0] fp_lut(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3800B700: return 16'h2C00;
      32'h3C003C00: return 16'h4000;
      32'h3C004000: return 16'h4200;
      32'h40004000: return 16'h4400;
      32'h42003C00: return 16'h4400;
      default:      return 16'h7E00;
    endcase
  endfunction

  logic [15:0] ans1;
  logic [15:0] pipe3 [3];
  // Adder stand-ins: 1-stage for dut1, 3-stage pipeline for dut3.
  always @(posedge clk) begin
    ans1     <= fp_lut(bus1.add_a, bus1.add_b);
    pipe3[0] <= fp_lut(bus3.add_a, bus3.add_b);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus1.add_ans = ans1;
  assign bus3.add_ans = pipe3[2];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] data;
  } exp_t;
  exp_t q1[$];
  exp_t q3[$];

  // Monitor: pop the scoreboard on every response handshake, police req_ready.
  always @(negedge clk) begin
    exp_t e;
    chk("ready_onehot1", 32'($onehot0(bus1.req_ready)), 32'd1);
    chk("ready_onehot3", 32'($onehot0(bus3.req_ready)), 32'd1);
    if (rst_n && bus1.rsp_valid && bus1.rsp_ready) begin
      if (q1.size() == 0) begin
        checks++; fails++;
        $display("FAIL rsp1_unexpected actual id=%0d data=%h required=none",
                 bus1.rsp_id, bus1.rsp_data);
      end else begin
        e = q1.pop_front();
        chk("rsp1_id", 32'(bus1.rsp_id), 32'(e.id));
        chk("rsp1_data", 32'(bus1.rsp_data), 32'(e.data));
      end
    end
    if (rst_n && bus3.rsp_valid && bus3.rsp_ready) begin
      if (q3.size() == 0) begin
        checks++; fails++;
        $display("FAIL rsp3_unexpected actual id=%0d data=%h required=none",
                 bus3.rsp_id, bus3.rsp_data);
      end else begin
        e = q3.pop_front();
        chk("rsp3_id", 32'(bus3.rsp_id), 32'(e.id));
        chk("rsp3_data", 32'(bus3.rsp_data), 32'(e.data));
      end
    end
  end

  // Called at the negedge after acceptance; returns edges-after-acceptance until rsp_valid.
  task automatic wait_rsp1(output int n);
    n = 1;
    while (n <= 20) begin
      @(negedge clk);
      if (bus1.rsp_valid) return;
      n++;
    end
    n = -1;
  endtask

  task automatic wait_rsp3(output int n);
    n = 1;
    while (n <= 20) begin
      @(negedge clk);
      if (bus3.rsp_valid) return;
      n++;
    end
    n = -1;
  endtask

  // One complete operation on dut1; returns at the negedge after the response handshake.
  task automatic op1(input int id, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] sum);
    int n;
    @(posedge clk); #1;
    bus1.req_a[16*id +: 16] = a;
    bus1.req_b[16*id +: 16] = b;
    bus1.req_valid = '0;
    bus1.req_valid[id] = 1'b1;
    q1.push_back({3'(id), sum});
    @(negedge clk);
    chk("op1_grant", 32'(bus1.req_ready), 32'd1 << id);
    @(posedge clk); #1;
    bus1.req_valid = '0;
    @(negedge clk);
    chk("op1_busy", 32'(bus1.busy), 32'd1);
    chk("op1_early_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("op1_add_a", 32'(bus1.add_a), 32'(a));
    chk("op1_add_b", 32'(bus1.add_b), 32'(b));
    wait_rsp1(n);
    chk("op1_latency", 32'(n), 32'd2);
    @(negedge clk);
  endtask

  task automatic op3(input int id, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] sum);
    int n;
    @(posedge clk); #1;
    bus3.req_a[16*id +: 16] = a;
    bus3.req_b[16*id +: 16] = b;
    bus3.req_valid = '0;
    bus3.req_valid[id] = 1'b1;
    q3.push_back({3'(id), sum});
    @(negedge clk);
    chk("op3_grant", 32'(bus3.req_ready), 32'd1 << id);
    @(posedge clk); #1;
    bus3.req_valid = '0;
    @(negedge clk);
    chk("op3_busy", 32'(bus3.busy), 32'd1);
    wait_rsp3(n);
    chk("op3_latency", 32'(n), 32'd4);
    @(negedge clk);
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_req_ready"}, 32'(bus1.req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus1.rsp_valid), 32'd0);
    chk({tag, "_busy"},      32'(bus1.busy), 32'd0);
    chk({tag, "_rsp_id"},    32'(bus1.rsp_id), 32'd0);
    chk({tag, "_rsp_data"},  32'(bus1.rsp_data), 32'd0);
    chk({tag, "_add_a"},     32'(bus1.add_a), 32'd0);
    chk({tag, "_add_b"},     32'(bus1.add_b), 32'd0);
    chk({tag, "_ops_done"},  32'(bus1.ops_done), 32'd0);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5];
    int n;
    order = '{0, 1, 2, 3, 0};
    bus1.req_a = '0; bus1.req_b = '0; bus1.rsp_ready = 1'b1;
    bus3.req_a = '0; bus3.req_b = '0; bus3.rsp_ready = 1'b1;
    // Requests asserted during reset must never be granted.
    bus1.req_valid = 4'hF;
    bus3.req_valid = 4'hF;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset1("rst");
    chk("rst_req_ready3", 32'(bus3.req_ready), 32'd0);
    bus1.req_valid = '0;
    bus3.req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single op
    op1(0, 16'h3800, 16'hB700, 16'h2C00);
    chk("t1_ops_done", 32'(bus1.ops_done), 32'd1);
    chk("t1_idle", 32'(bus1.busy), 32'd0);
    chk("t1_add_a_held", 32'(bus1.add_a), 32'h3800);

    // Backpressure: hold RESP for more than 10 cycles, with other requesters valid.
    @(posedge clk); #1;
    bus1.rsp_ready = 1'b0;
    bus1.req_a[47:32] = 16'h3C00;
    bus1.req_b[47:32] = 16'h4000;
    bus1.req_valid = 4'b0100;
    q1.push_back({3'd2, 16'h4200});
    @(negedge clk);
    chk("t3_grant", 32'(bus1.req_ready), 32'h4);
    @(posedge clk); #1;
    bus1.req_valid = 4'b1011;
    @(negedge clk);
    wait_rsp1(n);
    chk("t3_latency", 32'(n), 32'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(bus1.rsp_valid), 32'd1);
      chk("t3_hold_id", 32'(bus1.rsp_id), 32'd2);
      chk("t3_hold_data", 32'(bus1.rsp_data), 32'h4200);
      chk("t3_hold_busy", 32'(bus1.busy), 32'd1);
      chk("t3_no_grant", 32'(bus1.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus1.req_valid = '0;
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_valid_fall", 32'(bus1.rsp_valid), 32'd0);
    chk("t3_idle", 32'(bus1.busy), 32'd0);
    chk("t3_ops_done", 32'(bus1.ops_done), 32'd2);

    // Reset one cycle into WAIT: op on requester 3 must vanish.
    @(posedge clk); #1;
    bus1.req_a[63:48] = 16'h4000;
    bus1.req_b[63:48] = 16'h4000;
    bus1.req_valid = 4'b1000;
    @(negedge clk);
    chk("t4_grant", 32'(bus1.req_ready), 32'h8);
    @(posedge clk); #1;
    bus1.req_valid = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset1("t4");
    repeat (6) @(negedge clk);

    // Contention: all four valid, expect grants 0,1,2,3,0 spaced ADD_LAT+3 cycles.
    @(posedge clk); #1;
    for (int i = 0; i < int'(NR); i++) begin
      bus1.req_a[16*i +: 16] = 16'h3C00;
      bus1.req_b[16*i +: 16] = 16'h3C00;
    end
    bus1.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus1.req_ready == '0 && n < 20);
      chk("t2_gap", 32'(n), (k == 0) ? 32'd1 : 32'd4);
      chk("t2_grant", 32'(bus1.req_ready), 32'd1 << order[k]);
      q1.push_back({3'(order[k]), 16'h4000});
      @(posedge clk); #1;
      if (k == 4) bus1.req_valid = '0;
    end
    n = 0;
    while ((q1.size() != 0 || bus1.busy) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t2_drained", 32'(q1.size()), 32'd0);
    chk("t2_ops_done", 32'(bus1.ops_done), 32'd5);

    // Saturation: jump the counter near the top, then run three ops.
    @(posedge clk); #1;
    force dut1.ops_done_q = 16'hFFFD;
    @(posedge clk); #1;
    release dut1.ops_done_q;
    op1(1, 16'h3C00, 16'h3C00, 16'h4000);
    chk("t5_ops_fffe", 32'(bus1.ops_done), 32'hFFFE);
    op1(1, 16'h3C00, 16'h3C00, 16'h4000);
    chk("t5_ops_ffff", 32'(bus1.ops_done), 32'hFFFF);
    op1(1, 16'h3C00, 16'h3C00, 16'h4000);
    chk("t5_ops_sat", 32'(bus1.ops_done), 32'hFFFF);

    // Latency sweep on the ADD_LAT=3 instance.
    op3(0, 16'h3C00, 16'h4000, 16'h4200);
    op3(1, 16'h4200, 16'h3C00, 16'h4400);
    chk("t6_ops_done", 32'(bus3.ops_done), 32'd2);

    repeat (4) @(negedge clk);
    chk("end_q1_empty", 32'(q1.size()), 32'd0);
    chk("end_q3_empty", 32'(q3.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
